// File: rtl/line_clear_scorer.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_scorer
// Description : Converts piece-lock events (lines cleared, level) into a point
//               value, queues the points in a saturating pending accumulator
//               and drains them as one-cycle score pulses. Each high cycle of
//               score_o is exactly one point for the downstream display
//               counter. Pulses are separated by PULSE_GAP low cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: SCORE_B2B_EN
//   Defined   : back-to-back flag; a 4-line clear following a 4-line clear
//               (with no 1-3 line clear in between) scores base 12, not 8.
//   Undefined : no flag; a 4-line clear always scores base 8.
// ----------------------------------------------------------------------------
// Ports:
//   clk             in   1        system clock
//   reset           in   1        asynchronous, active-high reset
//   lock_valid_i    in   1        one-cycle strobe: a piece locked this cycle
//   lines_cleared_i in   3        lines cleared by this lock (0-4 valid)
//   level_i         in   LEVEL_W  current level, sampled with lock_valid_i
//   score_o         out  1        one-cycle point pulse
//   pending_o       out  PEND_W   points not yet pulsed out
//   idle_o          out  1        FSM idle and nothing pending
//   overflow_o      out  1        sticky: an add saturated the accumulator
// ============================================================================
module line_clear_scorer #(
    parameter int PEND_W    = 8,
    parameter int PULSE_GAP = 1,
    parameter int LEVEL_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lock_valid_i,
    input  logic [2:0]         lines_cleared_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic               score_o,
    output logic [PEND_W-1:0]  pending_o,
    output logic               idle_o,
    output logic               overflow_o
);

    // Base points need 4 bits (max 12); level+1 needs LEVEL_W+1 bits.
    localparam int C_ADD_W = LEVEL_W + 5;
    // One extra bit above the wider operand so a saturating sum is visible.
    localparam int C_SUM_W = ((PEND_W > C_ADD_W) ? PEND_W : C_ADD_W) + 1;
    localparam int C_GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

    localparam logic [PEND_W-1:0]  C_PEND_MAX = '1;
    localparam logic [C_GAP_W-1:0] C_GAP_LAST =
        C_GAP_W'((PULSE_GAP > 0) ? (PULSE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PEND_W-1:0]    pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic [C_GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [3:0]           w_base;
    logic [LEVEL_W:0]     w_level_p1;
    logic [C_ADD_W-1:0]   w_add;
    logic [C_ADD_W-1:0]   w_add_gated;
    logic                 w_dec;
    logic [C_SUM_W-1:0]   w_sum;
    logic                 w_sat;
    logic                 w_gap_last;

`ifdef SCORE_B2B_EN
    logic                 b2b_q, b2b_d;

    always_comb begin
        w_base = 4'd0;
        case (lines_cleared_i)
            3'd1:    w_base = 4'd1;
            3'd2:    w_base = 4'd3;
            3'd3:    w_base = 4'd5;
            3'd4:    w_base = b2b_q ? 4'd12 : 4'd8;
            default: w_base = 4'd0;
        endcase
    end

    // 4-line clear arms the flag, any 1-3 line clear disarms it; no-clear
    // locks (0 and the invalid 5-7) leave it alone.
    always_comb begin
        b2b_d = b2b_q;
        if (lock_valid_i) begin
            if (lines_cleared_i == 3'd4) begin
                b2b_d = 1'b1;
            end else if ((lines_cleared_i != 3'd0) && (lines_cleared_i < 3'd4)) begin
                b2b_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b2b_q <= 1'b0;
        end else begin
            b2b_q <= b2b_d;
        end
    end
`else
    always_comb begin
        w_base = 4'd0;
        case (lines_cleared_i)
            3'd1:    w_base = 4'd1;
            3'd2:    w_base = 4'd3;
            3'd3:    w_base = 4'd5;
            3'd4:    w_base = 4'd8;
            default: w_base = 4'd0;
        endcase
    end
`endif

    assign w_level_p1  = {1'b0, level_i} + (LEVEL_W + 1)'(1);
    assign w_add       = C_ADD_W'(w_base) * C_ADD_W'(w_level_p1);
    assign w_add_gated = lock_valid_i ? w_add : '0;

    // The point is consumed on the edge that leaves PULSE. PULSE is only
    // entered with pending >= 1, so the subtraction never wraps.
    assign w_dec = (state_q == ST_PULSE);
    assign w_sum = C_SUM_W'(pending_q) + C_SUM_W'(w_add_gated) - C_SUM_W'(w_dec);
    assign w_sat = (w_sum > C_SUM_W'(C_PEND_MAX));

    always_comb begin
        pending_d  = w_sat ? C_PEND_MAX : w_sum[PEND_W-1:0];
        overflow_d = overflow_q | w_sat;
    end

    assign w_gap_last = (gap_cnt_q == C_GAP_LAST);

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        score_o   = 1'b0;
        idle_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_o = (pending_q == '0);
                if (pending_q != '0) begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                score_o   = 1'b1;
                gap_cnt_d = '0;
                if (PULSE_GAP > 0) begin
                    state_d = ST_GAP;
                end else if (pending_d != '0) begin
                    // Zero-gap mode: keep pulsing while anything remains
                    // after this point (including a same-edge add).
                    state_d = ST_PULSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_gap_last) begin
                    gap_cnt_d = '0;
                    state_d   = (pending_q != '0) ? ST_PULSE : ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + C_GAP_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_scorer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_line_clear_scorer
// Description : Self-checking bench for line_clear_scorer. A points-level
//               reference model (pending integer, time of last pulse) predicts
//               every output each cycle; scenario tasks add directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_clear_scorer;

    localparam int PEND_W    = 8;
    localparam int PULSE_GAP = 1;
    localparam int LEVEL_W   = 4;
    localparam int PEND_MAX  = (1 << PEND_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               lock_valid;
    logic [2:0]         lines_cleared;
    logic [LEVEL_W-1:0] level;
    logic               score;
    logic [PEND_W-1:0]  pending;
    logic               idle;
    logic               overflow;

    line_clear_scorer #(
        .PEND_W    (PEND_W),
        .PULSE_GAP (PULSE_GAP),
        .LEVEL_W   (LEVEL_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lock_valid_i    (lock_valid),
        .lines_cleared_i (lines_cleared),
        .level_i         (level),
        .score_o         (score),
        .pending_o       (pending),
        .idle_o          (idle),
        .overflow_o      (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: points owed, whether the current cycle is a pulse,
    // and the cycle of the most recent completed pulse.
    int m_pend;
    int m_last;
    int m_cyc;
    bit m_score;
    bit m_ovf;
    bit m_b2b;

    logic [PEND_W+2:0] got, exp;

    function automatic int base_points(input int lines);
        case (lines)
            1: return 1;
            2: return 3;
            3: return 5;
            4: begin
`ifdef SCORE_B2B_EN
                if (m_b2b) return 12;
`endif
                return 8;
            end
            default: return 0;
        endcase
    endfunction

    function automatic bit model_idle();
        return (m_pend == 0) && !m_score && (m_cyc - m_last > PULSE_GAP);
    endfunction

    task automatic model_reset();
        m_pend  = 0;
        m_last  = -100;
        m_cyc   = 0;
        m_score = 1'b0;
        m_ovf   = 1'b0;
        m_b2b   = 1'b0;
    endtask

    // A pulse is due when points were owed last cycle and at least PULSE_GAP
    // cycles have passed since the previous pulse.
    task automatic model_edge(input bit lv, input int lines, input int lvl);
        int add;
        int nxt;
        bit ns;
        if (m_score) m_last = m_cyc;
        ns  = (m_pend > 0) && (m_cyc - m_last >= PULSE_GAP);
        add = lv ? base_points(lines) * (lvl + 1) : 0;
        if (lv && lines == 4) m_b2b = 1'b1;
        else if (lv && lines >= 1 && lines <= 3) m_b2b = 1'b0;
        nxt = m_pend + add - (m_score ? 1 : 0);
        if (nxt > PEND_MAX) begin
            nxt   = PEND_MAX;
            m_ovf = 1'b1;
        end
        m_pend  = nxt;
        m_score = ns;
        m_cyc++;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, and
    // return 1 ns after the edge with lock_valid dropped again.
    task automatic step(input bit lv, input int lines, input int lvl);
        lock_valid    = lv;
        lines_cleared = 3'(lines);
        level         = LEVEL_W'(lvl);
        @(posedge clk);
        model_edge(lv, lines, lvl);
        #1;
        lock_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        lock_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        lock_valid    = 1'b0;
        lines_cleared = 3'd0;
        level         = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        got = {score, pending, idle, overflow};
        exp = {1'b0, PEND_W'(0), 1'b1, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_state got=%h expected=%h", got, exp);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_lock();
        do_reset();
        step(1'b1, 1, 0);
        n_vec++;
        if (pending !== 8'd1 || score !== 1'b0) begin
            n_err++;
            $display("FAIL single_c1 pending=%0d score=%0b expected pending=1 score=0", pending, score);
        end
        step(1'b0, 0, 0);
        n_vec++;
        if (score !== 1'b1 || pending !== 8'd1) begin
            n_err++;
            $display("FAIL single_c2 score=%0b pending=%0d expected score=1 pending=1", score, pending);
        end
        step(1'b0, 0, 0);
        n_vec++;
        if (score !== 1'b0 || pending !== 8'd0) begin
            n_err++;
            $display("FAIL single_c3 score=%0b pending=%0d expected score=0 pending=0", score, pending);
        end
        step(1'b0, 0, 0);
        n_vec++;
        if (idle !== 1'b1 || score !== 1'b0) begin
            n_err++;
            $display("FAIL single_c4 idle=%0b score=%0b expected idle=1 score=0", idle, score);
        end
    endtask

    task automatic test_tetris_burst();
        int  pulses;
        int  last;
        bit  done;
        do_reset();
        step(1'b1, 4, 2);
        pulses = 0;
        last   = -1;
        done   = 1'b0;
        for (int i = 0; i < 120 && !done; i++) begin
            step(1'b0, 0, 0);
            n_vec++;
            got = {score, pending, idle, overflow};
            exp = {m_score, PEND_W'(m_pend), model_idle(), m_ovf};
            if (got !== exp) begin
                n_err++;
                $display("FAIL burst_cycle cyc=%0d got=%h expected=%h", m_cyc, got, exp);
            end
            if (score === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (i - last != PULSE_GAP + 1) begin
                        n_err++;
                        $display("FAIL burst_spacing spacing=%0d expected=%0d", i - last, PULSE_GAP + 1);
                    end
                end
                last = i;
                pulses++;
            end
            if (model_idle()) done = 1'b1;
        end
        n_vec++;
        if (!done || pulses != 24 || pending !== 8'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL burst_total pulses=%0d pending=%0d ovf=%0b done=%0b expected 24/0/0/1",
                     pulses, pending, overflow, done);
        end
    endtask

    task automatic test_add_during_burst();
        int pulses;
        bit done;
        do_reset();
        step(1'b1, 3, 1);
        step(1'b0, 0, 0);
        n_vec++;
        if (score !== 1'b1 || pending !== 8'd10) begin
            n_err++;
            $display("FAIL midburst_setup score=%0b pending=%0d expected score=1 pending=10", score, pending);
        end
        pulses = (score === 1'b1) ? 1 : 0;
        step(1'b1, 2, 0);
        n_vec++;
        if (pending !== 8'd12) begin
            n_err++;
            $display("FAIL midburst_add pending=%0d expected=12", pending);
        end
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step(1'b0, 0, 0);
            n_vec++;
            got = {score, pending, idle, overflow};
            exp = {m_score, PEND_W'(m_pend), model_idle(), m_ovf};
            if (got !== exp) begin
                n_err++;
                $display("FAIL midburst_cycle cyc=%0d got=%h expected=%h", m_cyc, got, exp);
            end
            if (score === 1'b1) pulses++;
            if (model_idle()) done = 1'b1;
        end
        n_vec++;
        if (!done || pulses != 13) begin
            n_err++;
            $display("FAIL midburst_total pulses=%0d done=%0b expected 13/1", pulses, done);
        end
    endtask

    task automatic test_saturation();
        int pulses;
        bit done;
        do_reset();
        step(1'b1, 4, 15);
        step(1'b1, 4, 15);
        n_vec++;
        if (pending !== 8'd255 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL sat_value pending=%0d ovf=%0b expected 255/1", pending, overflow);
        end
        pulses = (score === 1'b1) ? 1 : 0;
        done   = 1'b0;
        for (int i = 0; i < 700 && !done; i++) begin
            step(1'b0, 0, 0);
            n_vec++;
            got = {score, pending, idle, overflow};
            exp = {m_score, PEND_W'(m_pend), model_idle(), m_ovf};
            if (got !== exp) begin
                n_err++;
                $display("FAIL sat_cycle cyc=%0d got=%h expected=%h", m_cyc, got, exp);
            end
            if (score === 1'b1) pulses++;
            if (model_idle()) done = 1'b1;
        end
        n_vec++;
        if (!done || pulses != 255 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL sat_total pulses=%0d ovf=%0b done=%0b expected 255/1/1", pulses, overflow, done);
        end
        do_reset();
        #1;
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL sat_clear ovf=%0b expected=0", overflow);
        end
    endtask

    task automatic test_async_reset();
        int  pulses;
        bit  found;
        do_reset();
        step(1'b1, 4, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 0, 0);
            if (score === 1'b1 && pending === 8'd7) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL areset_setup pulse with pending=7 not seen, pending=%0d", pending);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        got = {score, pending, idle, overflow};
        exp = {1'b0, PEND_W'(0), 1'b1, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL areset_immediate got=%h expected=%h", got, exp);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 0, 0);
            if (score === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0 || pending !== 8'd0 || idle !== 1'b1) begin
            n_err++;
            $display("FAIL areset_after pulses=%0d pending=%0d idle=%0b expected 0/0/1", pulses, pending, idle);
        end
    endtask

    task automatic test_no_clear();
        int pulses;
        int want;
        bit done;
        do_reset();
        pulses = 0;
        step(1'b1, 0, 5);
        step(1'b1, 5, 3);
        step(1'b1, 7, 15);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 0);
            if (score === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0 || pending !== 8'd0 || idle !== 1'b1) begin
            n_err++;
            $display("FAIL noclear pulses=%0d pending=%0d idle=%0b expected 0/0/1", pulses, pending, idle);
        end
`ifdef SCORE_B2B_EN
        want = 20;
`else
        want = 16;
`endif
        step(1'b1, 4, 0);
        step(1'b1, 4, 0);
        pulses = (score === 1'b1) ? 1 : 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step(1'b0, 0, 0);
            n_vec++;
            got = {score, pending, idle, overflow};
            exp = {m_score, PEND_W'(m_pend), model_idle(), m_ovf};
            if (got !== exp) begin
                n_err++;
                $display("FAIL b2b_cycle cyc=%0d got=%h expected=%h", m_cyc, got, exp);
            end
            if (score === 1'b1) pulses++;
            if (model_idle()) done = 1'b1;
        end
        n_vec++;
        if (!done || pulses != want) begin
            n_err++;
            $display("FAIL b2b_total pulses=%0d expected=%0d done=%0b", pulses, want, done);
        end
    endtask

    task automatic test_random();
        bit lv;
        int ln;
        int lvl;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            lv  = ($urandom_range(0, 5) == 0);
            ln  = $urandom_range(0, 7);
            lvl = $urandom_range(0, (1 << LEVEL_W) - 1);
            step(lv, ln, lvl);
            n_vec++;
            got = {score, pending, idle, overflow};
            exp = {m_score, PEND_W'(m_pend), model_idle(), m_ovf};
            if (got !== exp) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h expected=%h", m_cyc, got, exp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_lock();
        test_tetris_burst();
        test_add_during_burst();
        test_saturation();
        test_async_reset();
        test_no_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
